fsm_input_debounce: RTL
=======================

# fsm_input_debounce

Two-channel input conditioner that sits directly upstream of the two-input example FSMs and produces their `a`/`b` inputs from raw mechanical switches or buttons. Each channel synchronises its raw input, rejects bounce with a stability counter, and outputs a clean debounced level plus a one-cycle rising-edge tick. Both channels are identical and fully independent.

## Interface

- `DB_CNT`, default 1000000: consecutive stable cycles required before a level change is accepted; 10 ms at 100 MHz; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sw_a`  in  1  raw, asynchronous, bouncy switch input, channel A.
- `sw_b`  in  1  raw, asynchronous, bouncy switch input, channel B.
- `a`  out  1  debounced level, channel A; feeds the FSM `a` input.
- `b`  out  1  debounced level, channel B; feeds the FSM `b` input.
- `a_tick`  out  1  one-cycle pulse on an accepted 0→1 change of `a`.
- `b_tick`  out  1  one-cycle pulse on an accepted 0→1 change of `b`.

## Operation

- Per channel: optional 2-flop synchroniser (see Configuration) → sampled signal `s` → 4-state debounce FSM with counter `cnt`.
- `cnt` width is `$clog2(DB_CNT)`; it only loads and decrements, never wraps.
- FSM states and transitions:
  - ZERO: if `s`=1, go to WAIT1 and load `cnt`=DB_CNT-1.
  - WAIT1: if `s`=0, return to ZERO. If `s`=1 and `cnt`=0, go to ONE and set tick for one cycle. Otherwise decrement `cnt`.
  - ONE: if `s`=0, go to WAIT0 and load `cnt`=DB_CNT-1.
  - WAIT0: if `s`=1, return to ONE. If `s`=0 and `cnt`=0, go to ZERO. Otherwise decrement `cnt`.
- Level output is 1 in ONE and WAIT0, and 0 in ZERO and WAIT1. It is decoded from the state register, so it is glitch-free.
- Tick is a registered flop. It is set only on the WAIT1→ONE transition and is high for exactly one cycle.
- No tick is produced on a falling edge or on a WAIT0→ONE return.
- Any bounce shorter than DB_CNT stable cycles is fully rejected: the level output does not change and no tick is produced.
- Channels never interact. Simultaneous events on A and B are handled independently, and both ticks may be high in the same cycle.

## Timing

- Reset (`reset`=0 at a clock edge):
  - state becomes ZERO, `cnt`=0, synchroniser flops 0.
  - `a`=`b`=`a_tick`=`b_tick`=0 from that edge on, regardless of `sw_*`.
- Reset asserted mid-debounce (WAIT1/WAIT0) aborts the debounce. After release, a full DB_CNT stable window is required again.
- Let E0 be the first edge at which the raw input is captured high and stays stable. Edges are counted from E0.
- With DB_SYNC_EN:
  - `s` is high after E1; the FSM enters WAIT1 at E2.
  - ONE is entered at E(DB_CNT+2), so `a` rises and `a_tick` is high during the cycle after E(DB_CNT+2).
  - Rise latency is DB_CNT+2 cycles.
- Without DB_SYNC_EN:
  - The FSM samples the raw input directly and enters WAIT1 at E0.
  - `a` and `a_tick` rise after E(DB_CNT).
  - Rise latency is DB_CNT cycles.
- Fall latency is the same as rise latency (DB_CNT+2 with sync, DB_CNT without). No tick accompanies a fall.
- A single opposite-level sample during WAIT1/WAIT0 restarts the window. Latency is then measured from the last qualifying capture edge.

## Configuration

- Macro: `FSM_DB_SYNC_EN`.
- Defined: each channel has a 2-flop synchroniser in front of the FSM; latency is DB_CNT+2. This is the mandatory setting for physical switch inputs.
- Undefined: synchronisers are removed and the FSM samples `sw_*` directly; latency is DB_CNT. Only for simulation or already-synchronous sources.
- Ports, reset values and FSM behaviour are otherwise identical.

## Test plan

- Reset: hold `reset`=0 for 3 cycles with `sw_a`=`sw_b`=1, DB_CNT=4, FSM_DB_SYNC_EN defined → all outputs 0 throughout. After release, `a`=`b`=1 and both ticks pulse exactly 6 edges after the first capturing edge.
- Clean press: `sw_a` goes 0→1 and is held 10 cycles, DB_CNT=4, sync on → `a` rises 6 edges after capture. `a_tick` is high for exactly the first cycle `a` is 1. `b` and `b_tick` stay 0.
- Bounce: `sw_a` pattern 1,1,1,0,1,1,1,1,1 with DB_CNT=4 → no tick and `a`=0 until 4 stable samples follow the last 0. Exactly one tick.
- Release: `sw_a` goes 1→0 from the ONE state, DB_CNT=4 → `a` falls 6 edges later; `a_tick` stays 0. A 2-cycle low glitch leaves `a`=1.
- Reset mid-debounce: drive `reset`=0 while channel A is in WAIT1 with `cnt`=1 → `a` stays 0 and no tick. After release, a full 4-cycle window is required again.
- Macro off: repeat the clean-press scenario without FSM_DB_SYNC_EN → `a` and `a_tick` rise 4 edges after capture. Simultaneous presses on A and B → both ticks are high in the same cycle.

Source files
------------

// File: rtl/fsm_input_debounce_if.sv
// Raw switch inputs and conditioned level/tick outputs of fsm_input_debounce.
// master drives the raw switches and observes; slave is the debouncer side.
`timescale 1ns/1ps

interface fsm_input_debounce_if;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_tick;
  logic b_tick;

  modport master (
    output sw_a, sw_b,
    input  a, b, a_tick, b_tick
  );

  modport slave (
    input  sw_a, sw_b,
    output a, b, a_tick, b_tick
  );
endinterface

// File: rtl/fsm_input_debounce.sv
// Two independent switch debouncers producing a clean level and a rising-edge tick.
// Optional 2-flop input synchronisers are enabled by defining FSM_DB_SYNC_EN.
`timescale 1ns/1ps

module fsm_input_debounce #(
  parameter int unsigned DB_CNT = 1000000
) (
  input logic                 clk,
  input logic                 reset,
  fsm_input_debounce_if.slave bus
);

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = $clog2(DB_CNT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CNT - 1);

  // Bit 1 of the encoding is the debounced level, so the output is a flop bit.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] w_level;
  logic [NCH-1:0] w_tick;

  assign w_raw = {bus.sw_b, bus.sw_a};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_tick;
    logic          w_tick_nxt;
    logic          w_s;

`ifdef FSM_DB_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_s = r_sync2;
`else
    assign w_s = w_raw[g];
`endif

    // State, counter and tick registers
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state <= ZERO;
        r_cnt   <= '0;
        r_tick  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_tick  <= w_tick_nxt;
      end
    end

    // Next state and stability counter; the counter only loads or decrements
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
        ZERO: begin
          if (w_s) begin
            w_state_nxt = WAIT1;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        WAIT1: begin
          if (!w_s) begin
            w_state_nxt = ZERO;
          end else if (r_cnt == '0) begin
            w_state_nxt = ONE;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        ONE: begin
          if (!w_s) begin
            w_state_nxt = WAIT0;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        WAIT0: begin
          if (w_s) begin
            w_state_nxt = ONE;
          end else if (r_cnt == '0) begin
            w_state_nxt = ZERO;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
        default: begin
          w_state_nxt = ZERO;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Tick only on an accepted WAIT1 -> ONE transition
    always_comb begin
      w_tick_nxt = 1'b0;
      if ((r_state == WAIT1) && w_s && (r_cnt == '0)) begin
        w_tick_nxt = 1'b1;
      end
    end

    assign w_level[g] = r_state[1];
    assign w_tick[g]  = r_tick;
  end

  assign bus.a      = w_level[0];
  assign bus.b      = w_level[1];
  assign bus.a_tick = w_tick[0];
  assign bus.b_tick = w_tick[1];

endmodule
